// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard controller.
//   state_t             : controller states (RUN, MDU_WAIT)
//   MDU_LATENCY_DEFAULT : default multiply/divide stall length in cycles
//   REG_ZERO            : architectural zero register index
//   load_use_hazard()   : detects a dependency on a load still in ID/EX
// ---------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  localparam int          MDU_LATENCY_DEFAULT = 4;
  localparam logic [4:0]  REG_ZERO            = 5'd0;

  // A load into r0 never creates a dependency, because r0 is hardwired to
  // zero. The rt comparison only matters when the younger instruction
  // actually reads rt as a source.
  function automatic logic load_use_hazard(
    input logic       mem_read,
    input logic [4:0] ex_rt,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt,
    input logic       uses_rt
  );
    load_use_hazard = mem_read && (ex_rt != REG_ZERO) &&
                      ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for the hazard performance counters.
// Ports:
//   clk   : clock
//   clear : synchronous active-high clear (takes priority over inc)
//   inc   : count enable, one step per cycle
//   count : current count, sticks at all-ones instead of wrapping
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Clear wins so that cycles spent in reset are never counted.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller: taken-branch flush, load-use stall and
// multi-cycle multiply/divide stall, plus saturating stall/flush counters.
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   id_ex_mem_read    : ID/EX instruction is a load
//   id_ex_rt          : ID/EX destination register
//   if_id_rs/rt       : IF/ID source registers
//   if_id_uses_rt     : IF/ID instruction reads rt
//   branch_taken      : branch/jump resolved taken in EX
//   mdu_start         : multiply/divide entering EX
//   pc_write          : PC update enable
//   if_id_write       : IF/ID load enable
//   if_id_flush       : IF/ID loads a NOP
//   id_ex_bubble      : ID/EX loads a NOP control word
//   id_ex_hold        : ID/EX keeps its contents
//   mdu_busy          : multi-cycle MDU stall in progress
//   stall_cnt         : saturating count of cycles with pc_write=0
//   flush_cnt         : saturating count of cycles with if_id_flush=1
// ---------------------------------------------------------------------------
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MDU_LATENCY = MDU_LATENCY_DEFAULT,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rt,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             if_id_uses_rt,
  input  logic             branch_taken,
  input  logic             mdu_start,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             id_ex_hold,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // The start cycle is itself a stall cycle, so the wait state only has to
  // cover the remaining MDU_LATENCY-1 cycles.
  localparam logic [7:0] MDU_RELOAD = 8'(MDU_LATENCY - 1);

  state_t     state;
  logic [7:0] mdu_cnt;
  logic       load_use;

  assign load_use = load_use_hazard(id_ex_mem_read, id_ex_rt, if_id_rs,
                                    if_id_rt, if_id_uses_rt);

  // Control outputs are Mealy so that stalls and flushes take effect in the
  // very cycle the hazard is seen. Reset forces the idle pattern.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    id_ex_hold   = 1'b0;
    mdu_busy     = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (mdu_start) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_hold  = 1'b1;
            mdu_busy    = 1'b1;
          end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        MDU_WAIT: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_hold  = 1'b1;
          mdu_busy    = 1'b1;
        end
        default: begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end
      endcase
    end
  end

  // State and MDU down-counter. A taken branch squashes the MDU op, so the
  // stall only starts when mdu_start arrives without a branch. In MDU_WAIT
  // all other requests are ignored until the counter runs out.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      mdu_cnt <= 8'd0;
    end else begin
      case (state)
        RUN: begin
          if (!branch_taken && mdu_start) begin
            state   <= MDU_WAIT;
            mdu_cnt <= MDU_RELOAD;
          end
        end
        MDU_WAIT: begin
          mdu_cnt <= mdu_cnt - 8'd1;
          if (mdu_cnt == 8'd1) begin
            state <= RUN;
          end
        end
        default: begin
          state   <= RUN;
          mdu_cnt <= 8'd0;
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .clear(reset),
    .inc  (!pc_write),
    .count(stall_cnt)
  );

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .clear(reset),
    .inc  (if_id_flush),
    .count(flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Drives two controllers (16-bit and 4-bit counters) with the same inputs
// and compares both against a cycle-level reference model.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_ex_mem_read;
  logic [4:0] id_ex_rt;
  logic [4:0] if_id_rs;
  logic [4:0] if_id_rt;
  logic       if_id_uses_rt;
  logic       branch_taken;
  logic       mdu_start;

  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, mdu_busy;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble, s_id_ex_hold, s_mdu_busy;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining wait cycles and counter values.
  int rem      = 0;
  int m_stall  = 0;
  int m_flush  = 0;
  int m_stall4 = 0;
  int m_flush4 = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MDU_LATENCY(LAT), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .branch_taken(branch_taken), .mdu_start(mdu_start), .pc_write(pc_write),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .id_ex_hold(id_ex_hold), .mdu_busy(mdu_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.MDU_LATENCY(LAT), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .branch_taken(branch_taken), .mdu_start(mdu_start), .pc_write(s_pc_write),
    .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush), .id_ex_bubble(s_id_ex_bubble),
    .id_ex_hold(s_id_ex_hold), .mdu_busy(s_mdu_busy), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected outputs follow from the hazard rules; compare both instances.
  task automatic checkOutput(input string tag);
    bit e_pc, e_ifw, e_flush, e_bub, e_hold, e_busy, lu;
    lu = id_ex_mem_read && (id_ex_rt != 5'd0) &&
         ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
    {e_pc, e_ifw, e_flush, e_bub, e_hold, e_busy} = 6'b110000;
    if (!reset) begin
      if (rem > 0 || (!branch_taken && mdu_start)) begin
        {e_pc, e_ifw, e_hold, e_busy} = 4'b0011;
      end else if (branch_taken) begin
        {e_flush, e_bub} = 2'b11;
      end else if (lu) begin
        {e_pc, e_ifw, e_bub} = 3'b001;
      end
    end
    check({tag, ".pc_write"},     32'(pc_write),     32'(e_pc));
    check({tag, ".if_id_write"},  32'(if_id_write),  32'(e_ifw));
    check({tag, ".if_id_flush"},  32'(if_id_flush),  32'(e_flush));
    check({tag, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'(e_bub));
    check({tag, ".id_ex_hold"},   32'(id_ex_hold),   32'(e_hold));
    check({tag, ".mdu_busy"},     32'(mdu_busy),     32'(e_busy));
    check({tag, ".stall_cnt"},    32'(stall_cnt),    32'(m_stall));
    check({tag, ".flush_cnt"},    32'(flush_cnt),    32'(m_flush));
    check({tag, ".sat.pc_write"}, 32'(s_pc_write),   32'(e_pc));
    check({tag, ".sat.stall_cnt"}, 32'(s_stall_cnt), 32'(m_stall4));
    check({tag, ".sat.flush_cnt"}, 32'(s_flush_cnt), 32'(m_flush4));
    // Advance the model to the state after the coming clock edge.
    if (reset) begin
      rem = 0; m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
    end else begin
      if (!e_pc) begin
        if (m_stall  < 65535) m_stall++;
        if (m_stall4 < 15)    m_stall4++;
      end
      if (e_flush) begin
        if (m_flush  < 65535) m_flush++;
        if (m_flush4 < 15)    m_flush4++;
      end
      if (rem > 0) rem--;
      else if (!branch_taken && mdu_start) rem = LAT - 1;
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check before the
  // next rising edge.
  task automatic applyStimulus(input string tag, input bit rst, input bit mr,
                               input logic [4:0] rt, input logic [4:0] rs,
                               input logic [4:0] irt, input bit urt,
                               input bit bt, input bit ms);
    @(negedge clk);
    reset = rst; id_ex_mem_read = mr; id_ex_rt = rt; if_id_rs = rs;
    if_id_rt = irt; if_id_uses_rt = urt; branch_taken = bt; mdu_start = ms;
    #1;
    checkOutput(tag);
  endtask

  initial begin
    reset = 1'b1; id_ex_mem_read = 1'b0; id_ex_rt = '0; if_id_rs = '0;
    if_id_rt = '0; if_id_uses_rt = 1'b0; branch_taken = 1'b0; mdu_start = 1'b0;

    // Reset forces idle outputs even with every request active.
    applyStimulus("reset0", 1, 1, 5'd8, 5'd8, 5'd0, 0, 1, 1);
    applyStimulus("reset1", 1, 1, 5'd8, 5'd8, 5'd0, 0, 0, 1);
    applyStimulus("idle",   0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);

    // Single-cycle load-use stall on rs.
    applyStimulus("lu_rs",  0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0);
    applyStimulus("lu_after", 0, 0, 5'd8, 5'd8, 5'd0, 0, 0, 0);
    check("lu_stall_cnt_is_1", 32'(stall_cnt), 32'd1);

    // Zero register and unused rt never stall; used rt does.
    applyStimulus("lu_r0",     0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    applyStimulus("lu_rt_unused", 0, 1, 5'd9, 5'd3, 5'd9, 0, 0, 0);
    applyStimulus("lu_rt_used",   0, 1, 5'd9, 5'd3, 5'd9, 1, 0, 0);
    applyStimulus("lu_rt_after",  0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);

    // MDU stall of exactly LAT cycles from a clean counter.
    applyStimulus("mdu_rst", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    applyStimulus("mdu_start", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    for (int i = 0; i < LAT + 1; i++)
      applyStimulus("mdu_run", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    check("mdu_busy_done", 32'(mdu_busy), 32'd0);
    check("mdu_stall_cnt_is_4", 32'(stall_cnt), 32'd4);

    // Requests during the wait are ignored; load-use re-evaluated afterwards.
    applyStimulus("mdu2_start", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    applyStimulus("mdu2_bt",    0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 1);
    applyStimulus("mdu2_lu",    0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0);
    applyStimulus("mdu2_lu",    0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0);
    applyStimulus("mdu2_relu",  0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0);
    applyStimulus("mdu2_idle",  0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);

    // Branch outranks MDU start and load-use.
    applyStimulus("prio_rst", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    applyStimulus("prio",     0, 1, 5'd7, 5'd7, 5'd0, 0, 1, 1);
    applyStimulus("prio_after", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    check("prio_flush_cnt_is_1", 32'(flush_cnt), 32'd1);
    check("prio_no_mdu", 32'(mdu_busy), 32'd0);

    // Reset during the second wait cycle aborts the stall.
    applyStimulus("rmdu_start", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    applyStimulus("rmdu_w1",    0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    applyStimulus("rmdu_w2rst", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    applyStimulus("rmdu_after", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    check("rmdu_busy",  32'(mdu_busy),  32'd0);
    check("rmdu_pc",    32'(pc_write),  32'd1);
    check("rmdu_stall", 32'(stall_cnt), 32'd0);
    check("rmdu_flush", 32'(flush_cnt), 32'd0);

    // Held load-use hazard saturates the 4-bit counter.
    for (int i = 0; i < 20; i++)
      applyStimulus("sat_lu", 0, 1, 5'd12, 5'd12, 5'd0, 0, 0, 0);
    applyStimulus("sat_after", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    check("sat_stall_cnt_is_15", 32'(s_stall_cnt), 32'd15);
    check("sat_wide_is_20", 32'(stall_cnt), 32'd20);

    // Randomized traffic with small register indices to provoke matches.
    for (int i = 0; i < 600; i++) begin
      applyStimulus("rand",
                    ($urandom_range(0, 39) == 0),
                    $urandom_range(0, 1) == 1,
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 6) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
